// File: rtl/muldiv_seq_pkg.sv
// +-----------------------------------------------------------------+
// | muldiv_pkg : shared op codes, FSM states and constants           |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
`default_nettype none

package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int unsigned ITER    = 32;
  localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_seq_step.sv
// +-----------------------------------------------------------------+
// | muldiv_step : one shift-add (multiply) or restoring-divide step  |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
`default_nettype none

module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh_rem;
  logic [WIDTH:0] trial;

  assign sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};

  // rem < divisor always holds, so the trial fits in signed WIDTH+1 bits
  assign sh_rem = {acc_hi, acc_lo[WIDTH-1]};
  assign trial  = sh_rem - {1'b0, opnd};

  always_comb begin
    nxt_hi = sum[WIDTH:1];
    nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    if (div) begin
      nxt_hi = trial[WIDTH] ? sh_rem[WIDTH-1:0] : trial[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// +-----------------------------------------------------------------+
// | muldiv_seq : iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO  |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
`default_nettype none

module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CNT_W    = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0]   step_hi, step_lo, fix_hi, fix_lo;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic [CNT_W-1:0]   cnt;
  logic               sgn_q, sgn_r, dz_q;
  logic               accept, op_div, op_unsigned, a_neg, b_neg, q_div;

  assign accept      = start && ((state == S_IDLE) || (state == S_DONE));
  assign op_div      = (op == OP_DIV) || (op == OP_DIVU);
  assign op_unsigned = (op == OP_MULTU) || (op == OP_DIVU);
  assign a_neg       = !op_unsigned && a[WIDTH-1];
  assign b_neg       = !op_unsigned && b[WIDTH-1];
  assign a_mag       = a_neg ? (~a + 1'b1) : a;
  assign b_mag       = b_neg ? (~b + 1'b1) : b;
  assign q_div       = !((op_q == OP_MULT) || (op_q == OP_MULTU));

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .div    (q_div),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  // Sign correction; divide-by-zero leaves HI = a via the remainder path
  assign prod     = {acc_hi, acc_lo};
  assign prod_neg = ~prod + 1'b1;

  always_comb begin
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (q_div) begin
      if (sgn_q) fix_lo = ~acc_lo + 1'b1;
      if (sgn_r) fix_hi = ~acc_hi + 1'b1;
      if (dz_q)  fix_lo = DIVZ_LO[WIDTH-1:0];
    end else if (sgn_q) begin
      {fix_hi, fix_lo} = prod_neg;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (flush)                 state_nxt = S_IDLE;
        else if (cnt == CNT_LAST)  state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_RUN) || (state_nxt == S_FIX);
      done  <= (state_nxt == S_DONE);
      dz    <= (state_nxt == S_DONE) && dz_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MULT;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      sgn_q  <= 1'b0;
      sgn_r  <= 1'b0;
      dz_q   <= 1'b0;
    end else if (accept) begin
      op_q   <= op;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= op_div ? a_mag : b_mag;
      opnd   <= op_div ? b_mag : a_mag;
      sgn_q  <= a_neg ^ b_neg;
      sgn_r  <= a_neg;
      dz_q   <= op_div && (b == '0);
    end else if (state == S_RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + 1'b1;
    end else if (state == S_FIX) begin
      acc_hi <= fix_hi;
      acc_lo <= fix_lo;
    end
  end

  // Result lands on entry to DONE and is re-asserted during DONE so MTHI/MTLO lose
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if ((state == S_FIX) && !flush) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else if (state == S_DONE) begin
      hi <= acc_hi;
      lo <= acc_lo;
    end else if (state == S_IDLE) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed plan, control sequences and random ops
`default_nettype none

module tb_muldiv_seq;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, hi_we, lo_we, busy, done, dz;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;

  int          cyc = 0;
  int          vectors = 0;
  int          errs = 0;
  int          run = 0;
  int          last_run = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;
  exp_t        q[$];
  exp_t        mon_e;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Architectural reference: plain signed/unsigned arithmetic with MIPS quirks
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    longint      sa, sb, qq, rr;
    logic [63:0] p;
    sa   = $signed(x);
    sb   = $signed(y);
    r.dz = 1'b0;
    r.k  = 0;
    case (o)
      2'b00: begin p = 64'(sa * sb); r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin p = {32'd0, x} * {32'd0, y}; r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          r.hi = x; r.lo = 32'hFFFF_FFFF; r.dz = 1'b1;
        end else if (o == 2'b10) begin
          qq = sa / sb; rr = sa % sb;
          r.lo = 32'(qq); r.hi = 32'(rr);
        end else begin
          r.lo = x / y; r.hi = x % y;
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at edge+1; start is sampled on the following edge
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e   = model(o, x, y);
    e.k = cyc;
    q.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      vectors++; errs++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", bound);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) run++;
      else if (run != 0) begin last_run = run; run = 0; end
      if (done) begin
        if (q.size() == 0) begin
          vectors++; errs++;
          $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          check("hi",       64'(hi), 64'(mon_e.hi));
          check("lo",       64'(lo), 64'(mon_e.lo));
          check("dz",       64'(dz), 64'(mon_e.dz));
          check("latency",  64'(cyc - mon_e.k), 64'd34);
          check("busy_len", 64'(last_run), 64'd33);
          mdl_hi = mon_e.hi;
          mdl_lo = mon_e.lo;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [1:0]  dop[6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10};
  logic [31:0] da[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h0000_1234, 32'h8000_0000};
  logic [31:0] db[6]  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz",   64'(dz),   64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed plan, issued back-to-back in each DONE cycle
    for (int i = 0; i < 6; i++) begin
      issue(dop[i], da[i], db[i]);
      wait_done(40);
    end
    lo_we = 1'b1; wdata = 32'h1111_2222;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("lo_we_in_done", 64'(lo), 64'(mdl_lo));

    // start and MTHI while busy are ignored
    issue(2'b11, 32'd1000, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check("hi_we_busy", 64'(hi), 64'(mdl_hi));
    check("busy_still", 64'(busy), 64'd1);
    wait_done(40);
    @(posedge clk); #1;
    check("idle_after", 64'(busy), 64'd0);

    // flush during RUN step 5
    issue(2'b00, 32'd123, 32'd456);
    void'(q.pop_back());
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi",   64'(hi),   64'(mdl_hi));
    check("flush_lo",   64'(lo),   64'(mdl_lo));
    repeat (40) @(posedge clk);
    #1;

    // MTHI / MTLO in IDLE
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi", 64'(hi), 64'hA5A5_A5A5);
    mdl_hi = 32'hA5A5_A5A5;
    lo_we = 1'b1; wdata = 32'h5A5A_0001;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo", 64'(lo), 64'h5A5A_0001);
    check("mtlo_hi_kept", 64'(hi), 64'hA5A5_A5A5);

    // start and MTHI on the same edge: write lands, result overwrites later
    hi_we = 1'b1; wdata = 32'h1234_5678;
    issue(2'b11, 32'd50, 32'd7);
    hi_we = 1'b0;
    check("same_edge_mthi", 64'(hi), 64'h1234_5678);
    wait_done(40);
    @(posedge clk); #1;

    // asynchronous reset mid-RUN
    issue(2'b10, 32'hFFFF_0000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_dz",   64'(dz),   64'd0);
    check("arst_hi",   64'(hi),   64'd0);
    check("arst_lo",   64'(lo),   64'd0);
    q.delete();
    mdl_hi = '0; mdl_lo = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b01, 32'd6, 32'd7);
    wait_done(40);

    // random ops, randomly back-to-back or via IDLE
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
      issue(2'($urandom_range(0, 3)), rnd_val(), rnd_val());
      wait_done(40);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the pipelined MIPS execute stage. It covers MULT, MULTU, DIV and DIVU, which the single-cycle ALU cannot do. It owns the HI/LO register pair and runs one shift-add or shift-subtract step per cycle. The hazard unit stalls on `busy` and reads HI/LO for MFHI/MFLO.

## Interface
- `WIDTH`, 32, operand and HI/LO width; ITER = WIDTH steps per operation.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled on the clock edge.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`, `b`  in  WIDTH  operands: a = rs (multiplicand/dividend), b = rt (multiplier/divisor).
- `flush`  in  1  synchronous abort from pipeline flush.
- `hi_we`, `lo_we`  in  1  MTHI / MTLO write strobes.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO are updated in this cycle.
- `dz`  out  1  divide-by-zero flag, valid only with `done`.
- `hi`, `lo`  out  WIDTH  HI/LO register contents.

## Operation
- FSM states are IDLE, RUN, FIX and DONE.
- **IDLE / DONE + `start`**
  - Latch `op`.
  - Latch the magnitudes of `a` and `b`; signed ops take two's-complement absolute values.
  - Latch the result signs: quotient/product sign = sign(a) ^ sign(b), remainder sign = sign(a).
  - Clear the step counter, then go to RUN.
- **RUN, multiply:** shift-add on a 2×WIDTH accumulator. Each step adds the multiplicand to the upper half when the accumulator LSB is 1, using a (WIDTH+1)-bit sum with carry kept, then shifts right 1.
- **RUN, divide:** restoring division. Each step shifts {rem, quo} left 1 and forms trial = rem − divisor at WIDTH+1 bits. If the trial is non-negative, rem = trial and the quotient LSB = 1.
- **RUN exit:** leave for FIX after exactly ITER steps.
- **FIX:** negate the product, or the quotient and remainder independently, per the latched signs.
- **DONE:**
  - Write the product to HI/LO: upper word to HI, lower word to LO.
  - For divide, write remainder to HI and quotient to LO.
  - Assert `done`, then go to IDLE, or to RUN if `start` is high.
- **Divide by zero (b = 0):** same latency, dz = 1 in DONE, LO = 0xFFFFFFFF, HI = original `a`.
- **Signed overflow:** DIV 0x80000000 / −1 gives LO = 0x80000000, HI = 0, dz = 0. No special case is needed.
- **`start` while busy:** ignored.
- **`flush`:**
  - In RUN or FIX: go to IDLE next edge, no `done`, HI/LO unchanged.
  - In DONE: the result is still written.
- **`hi_we` / `lo_we`:**
  - Accepted only in IDLE or DONE; ignored while busy.
  - In DONE, the result write wins over `hi_we`/`lo_we`.
  - Same-edge `start` and `hi_we` in IDLE: the write lands, and the result later overwrites it.

## Timing
- Reset values: state IDLE, busy = 0, done = 0, dz = 0, hi = 0, lo = 0, internal accumulators 0.
- `start` sampled at edge k:
  - RUN during cycles k+1 … k+32.
  - FIX during cycle k+33.
  - DONE (`done` = 1, new HI/LO visible) during cycle k+34.
- Latency is 34 cycles start-to-done for every op, including divide by zero.
- `busy` = 1 during cycles k+1 … k+33; 0 in IDLE and DONE.
- Back-to-back: `start` in the DONE cycle accepted, next `done` 34 cycles later.
- `rst_n` low at any time: immediately forces the reset values, aborting any operation.
- All outputs are registered; `done` and `dz` are not combinational from inputs.

## Structure
- Shared package `muldiv_pkg` holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - FSM state typedef;
  - ITER constant;
  - DIVZ_LO constant 0xFFFFFFFF.
- One combinational sub-module, `muldiv_step`. It takes the accumulator halves, the operand and a mode bit. It returns the next accumulator using a (WIDTH+1)-bit add/sub with carry/borrow.
- The FSM, counter, sign fix and HI/LO registers live in `muldiv_seq`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001, `done` exactly 34 cycles after `start`, `busy` high 33 cycles.
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 7 → LO = 14, HI = 2.
- DIV 0x00001234 / 0 → dz = 1, LO = 0xFFFFFFFF, HI = 0x00001234.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0, dz = 0.
- Control sequence:
  - `start` at cycle 10 while busy is ignored.
  - `flush` at RUN step 5 → IDLE next cycle, HI/LO unchanged, no `done`.
  - MTHI 0xA5A5A5A5 in IDLE → hi = 0xA5A5A5A5.
  - `rst_n` pulsed low mid-RUN → all outputs 0, FSM in IDLE.
